de_stream_decoder: RTL and testbench

Receive-side counterpart of the DE-mode LCD timing generator: consumes a data-enable-framed pixel stream (480x272 active, DE-only, no HSYNC/VSYNC) and recovers column/row coordinates, line/frame markers and a lock indication. It sits downstream of any DE-mode source, such as the pong renderer output or a loopback of the panel interface. Geometry is checked every line and frame, and lock is declared only after consecutive well-formed frames.

---
 rtl/de_stream_decoder_if.sv | 37 +++
 rtl/de_stream_decoder.sv | 173 +++++++++++++++++
 tb/tb_de_stream_decoder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/de_stream_decoder_if.sv
// de_stream_decoder_if
// Bundles the DE-framed input stream and the decoded output stream of
// de_stream_decoder.
//   i_data_enable / i_pixel : DE-framed pixel stream from the source
//   o_valid / o_pixel       : registered pixel strobe and data
//   o_col / o_row           : coordinates of o_pixel
//   o_sof / o_eol           : frame-start / line-end markers
//   o_locked                : geometry lock
//   o_err_line / o_err_frame: geometry error pulses
// Modports: slave = the decoder, master = the environment (source + sink).
interface de_stream_decoder_if #(
  parameter int PIX_W = 16
);
  logic             i_data_enable;
  logic [PIX_W-1:0] i_pixel;
  logic             o_valid;
  logic [PIX_W-1:0] o_pixel;
  logic [8:0]       o_col;
  logic [8:0]       o_row;
  logic             o_sof;
  logic             o_eol;
  logic             o_locked;
  logic             o_err_line;
  logic             o_err_frame;

  modport slave (
    input  i_data_enable, i_pixel,
    output o_valid, o_pixel, o_col, o_row, o_sof, o_eol,
           o_locked, o_err_line, o_err_frame
  );

  modport master (
    output i_data_enable, i_pixel,
    input  o_valid, o_pixel, o_col, o_row, o_sof, o_eol,
           o_locked, o_err_line, o_err_frame
  );
endinterface

// File: rtl/de_stream_decoder.sv
// de_stream_decoder
// Recovers column/row coordinates, line/frame markers and a geometry lock
// from a DE-only framed pixel stream. Vertical blanking is recognised as a
// DE-low run of VBLANK_GAP cycles. Lock is declared after LOCK_FRAMES
// consecutive well-formed frames.
// Ports:
//   i_clk   : pixel clock
//   i_rst_n : synchronous active-low reset
//   bus     : de_stream_decoder_if.slave (input stream in, decoded stream out)
module de_stream_decoder #(
  parameter int ACTIVE_H    = 480,
  parameter int ACTIVE_V    = 272,
  parameter int VBLANK_GAP  = 600,
  parameter int LOCK_FRAMES = 2,
  parameter int PIX_W       = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  de_stream_decoder_if.slave bus
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [9:0] GAP_N  = 10'(VBLANK_GAP);
  localparam logic [9:0] H_N    = 10'(ACTIVE_H);
  localparam logic [8:0] V_N    = 9'(ACTIVE_V);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  logic [1:0]       state_r;
  logic [9:0]       gap_r;
  logic [8:0]       col_r;
  logic [8:0]       row_r;
  logic [9:0]       line_cnt_r;
  logic             frame_bad_r;
  logic [3:0]       good_cnt_r;
  logic             valid_r;
  logic [PIX_W-1:0] pixel_r;
  logic [8:0]       out_col_r;
  logic [8:0]       out_row_r;
  logic             sof_r;
  logic             locked_r;
  logic             err_frame_r;

  logic             de_s;
  logic             vblank_s;
  logic             eol_s;
  logic             err_line_s;
  logic             frame_ok_s;
  logic [3:0]       good_inc_s;

  // Per-cycle decode of blanking, line end and frame quality.
  always_comb begin
    de_s       = bus.i_data_enable;
    // A DE-high cycle never counts as the vblank event, even at the threshold.
    vblank_s   = !de_s && (gap_r == GAP_N - 10'd1);
    // Line end is seen one cycle late: the delayed pixel is on the outputs
    // while the live DE has already dropped, so o_eol/o_err_line cannot be
    // registered without lookahead and are decoded from registered state.
    eol_s      = valid_r && !de_s;
    err_line_s = eol_s && (line_cnt_r != H_N);
    frame_ok_s = (row_r == V_N) && !frame_bad_r;
    if (good_cnt_r == 4'd15) begin
      good_inc_s = good_cnt_r;
    end else begin
      good_inc_s = good_cnt_r + 4'd1;
    end
  end

  // Gap counter, coordinate counters, lock state machine and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= ST_SEARCH;
      gap_r       <= 10'd0;
      col_r       <= 9'd0;
      row_r       <= 9'd0;
      line_cnt_r  <= 10'd0;
      frame_bad_r <= 1'b0;
      good_cnt_r  <= 4'd0;
      valid_r     <= 1'b0;
      pixel_r     <= '0;
      out_col_r   <= 9'd0;
      out_row_r   <= 9'd0;
      sof_r       <= 1'b0;
      locked_r    <= 1'b0;
      err_frame_r <= 1'b0;
    end else begin
      if (de_s) begin
        gap_r <= 10'd0;
      end else if (gap_r != GAP_N) begin
        gap_r <= gap_r + 10'd1;
      end

      valid_r     <= 1'b0;
      sof_r       <= 1'b0;
      err_frame_r <= 1'b0;

      case (state_r)
        ST_SEARCH: begin
          if (vblank_s) begin
            state_r     <= ST_ACQUIRE;
            row_r       <= 9'd0;
            col_r       <= 9'd0;
            line_cnt_r  <= 10'd0;
            good_cnt_r  <= 4'd0;
            frame_bad_r <= 1'b0;
          end
        end
        ST_ACQUIRE, ST_LOCKED: begin
          if (de_s) begin
            valid_r   <= 1'b1;
            pixel_r   <= bus.i_pixel;
            out_col_r <= col_r;
            out_row_r <= row_r;
            sof_r     <= (col_r == 9'd0) && (row_r == 9'd0);
            if (col_r != 9'd511) begin
              col_r <= col_r + 9'd1;
            end
            if (line_cnt_r != 10'd1023) begin
              line_cnt_r <= line_cnt_r + 10'd1;
            end
          end else if (eol_s) begin
            col_r      <= 9'd0;
            line_cnt_r <= 10'd0;
            if (row_r != 9'd511) begin
              row_r <= row_r + 9'd1;
            end
            // A malformed line spoils the frame and drops lock right away.
            if (err_line_s) begin
              frame_bad_r <= 1'b1;
              state_r     <= ST_ACQUIRE;
              locked_r    <= 1'b0;
            end
          end else if (vblank_s) begin
            row_r       <= 9'd0;
            col_r       <= 9'd0;
            line_cnt_r  <= 10'd0;
            frame_bad_r <= 1'b0;
            if (frame_ok_s) begin
              good_cnt_r <= good_inc_s;
              if (good_inc_s >= LOCK_N) begin
                state_r  <= ST_LOCKED;
                locked_r <= 1'b1;
              end
            end else begin
              // Bad line count is flagged here; bad lines were flagged already.
              err_frame_r <= (row_r != V_N);
              good_cnt_r  <= 4'd0;
              state_r     <= ST_ACQUIRE;
              locked_r    <= 1'b0;
            end
          end
        end
        default: begin
          state_r  <= ST_SEARCH;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_valid     = valid_r;
  assign bus.o_pixel     = pixel_r;
  assign bus.o_col       = out_col_r;
  assign bus.o_row       = out_row_r;
  assign bus.o_sof       = sof_r;
  assign bus.o_eol       = eol_s;
  assign bus.o_locked    = locked_r;
  assign bus.o_err_line  = err_line_s;
  assign bus.o_err_frame = err_frame_r;

endmodule

// File: tb/tb_de_stream_decoder.sv
// tb_de_stream_decoder
// Randomized DE-stream stimulus checked against a behavioural model of the
// decoder rules. A reduced geometry keeps frames short.
module tb_de_stream_decoder;
  localparam int H     = 20;
  localparam int V     = 5;
  localparam int GAP   = 30;
  localparam int LOCKN = 2;
  localparam int PW    = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  de_stream_decoder_if #(.PIX_W(PW)) bus ();

  de_stream_decoder #(
    .ACTIVE_H(H), .ACTIVE_V(V), .VBLANK_GAP(GAP), .LOCK_FRAMES(LOCKN), .PIX_W(PW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // model state: stream position and lock bookkeeping
  bit          m_active, m_locked, m_bad;
  int          m_col, m_row, m_lpix, m_good, m_run;
  bit          e_valid, e_sof, e_errf;
  logic [PW-1:0] e_pix;
  int          e_col, e_row;

  // per-frame observations
  int c_valid, c_eol, c_sof, c_errl, c_errf, max_col, snap_valid;
  bit prev_rst_low;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_locked = 1'b0; m_bad = 1'b0;
    m_col = 0; m_row = 0; m_lpix = 0; m_good = 0; m_run = 0;
    e_valid = 1'b0; e_sof = 1'b0; e_errf = 1'b0; e_pix = '0; e_col = 0; e_row = 0;
  endtask

  // One pixel-clock cycle: drive, compare, advance model, wait for edge.
  task automatic step(input bit rst_v, input bit de_v);
    logic [PW-1:0] p;
    bit x_eol, x_errl, vb, nv, ns, nerrf;
    logic [39:0] got, exp;
    p = PW'($urandom);
    rst_n = rst_v;
    bus.i_data_enable = de_v;
    bus.i_pixel = p;
    #1;
    x_eol  = e_valid && !de_v;
    x_errl = x_eol && (m_lpix != H);
    exp = {e_valid, e_valid ? e_pix : 16'h0, e_valid ? 9'(e_col) : 9'h0,
           e_valid ? 9'(e_row) : 9'h0, e_sof, x_eol, m_locked, x_errl, e_errf};
    got = {bus.o_valid, e_valid ? bus.o_pixel : 16'h0, e_valid ? bus.o_col : 9'h0,
           e_valid ? bus.o_row : 9'h0, bus.o_sof, bus.o_eol, bus.o_locked,
           bus.o_err_line, bus.o_err_frame};
    check("outputs", 64'(got), 64'(exp));
    if (prev_rst_low) begin
      check("zero_after_reset", 64'({bus.o_valid, bus.o_pixel, bus.o_col, bus.o_row,
            bus.o_sof, bus.o_eol, bus.o_locked, bus.o_err_line, bus.o_err_frame}), 64'd0);
    end
    prev_rst_low = !rst_v;
    c_valid += int'(bus.o_valid);
    c_eol   += int'(bus.o_eol);
    c_sof   += int'(bus.o_sof);
    c_errl  += int'(bus.o_err_line);
    c_errf  += int'(bus.o_err_frame);
    if (bus.o_valid && int'(bus.o_col) > max_col) max_col = int'(bus.o_col);

    if (!rst_v) begin
      model_reset();
    end else begin
      nv = 1'b0; ns = 1'b0; nerrf = 1'b0;
      vb = !de_v && (m_run == GAP - 1);
      if (m_active) begin
        if (de_v) begin
          nv = 1'b1; e_pix = p; e_col = m_col; e_row = m_row;
          ns = (m_col == 0) && (m_row == 0);
          if (m_col < 511) m_col++;
          m_lpix++;
        end else if (x_eol) begin
          if (m_lpix != H) begin
            m_bad = 1'b1; m_locked = 1'b0;
          end
          m_col = 0; m_lpix = 0;
          if (m_row < 511) m_row++;
        end else if (vb) begin
          if (m_row == V && !m_bad) begin
            if (m_good < 15) m_good++;
            if (m_good >= LOCKN) m_locked = 1'b1;
          end else begin
            nerrf = (m_row != V); m_good = 0; m_locked = 1'b0;
          end
          m_row = 0; m_col = 0; m_bad = 1'b0; m_lpix = 0;
        end
      end else if (vb) begin
        m_active = 1'b1; m_row = 0; m_col = 0; m_good = 0; m_bad = 1'b0; m_lpix = 0;
      end
      e_valid = nv; e_sof = ns; e_errf = nerrf;
      m_run = de_v ? 0 : ((m_run < GAP) ? m_run + 1 : m_run);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_vb();
    return int'($urandom_range(GAP + 1, GAP + 60));
  endfunction

  // One frame: nl lines, line odd_line has odd_len pixels, vertical blank of
  // vb_len DE-low cycles, optional one-cycle reset at cycle rst_at.
  task automatic frame(input int nl, input int odd_line, input int odd_len,
                       input int vb_len, input int rst_at);
    int hb, k;
    hb = int'($urandom_range(4, 8));
    k = 0;
    c_valid = 0; c_eol = 0; c_sof = 0; c_errl = 0; c_errf = 0; max_col = 0;
    snap_valid = 0;
    for (int l = 0; l < nl; l++) begin
      int len, gap;
      len = (l == odd_line) ? odd_len : H;
      gap = (l == nl - 1) ? vb_len : hb;
      for (int i = 0; i < len; i++) begin
        step(k != rst_at, 1'b1);
        if (k == rst_at) snap_valid = c_valid;
        k++;
      end
      for (int i = 0; i < gap; i++) begin
        step(k != rst_at, 1'b0);
        if (k == rst_at) snap_valid = c_valid;
        k++;
      end
    end
  endtask

  task automatic clean_counts();
    check("frame_valid", 64'(c_valid), 64'(H * V));
    check("frame_eol", 64'(c_eol), 64'(V));
    check("frame_sof", 64'(c_sof), 64'd1);
    check("frame_errl", 64'(c_errl), 64'd0);
    check("frame_errf", 64'(c_errf), 64'd0);
  endtask

  task automatic clean_pair_relock(input string tag);
    frame(V, -1, 0, rand_vb(), -1);
    clean_counts();
    check({tag, "_lock1"}, 64'(bus.o_locked), 64'd0);
    frame(V, -1, 0, rand_vb(), -1);
    clean_counts();
    check({tag, "_lock2"}, 64'(bus.o_locked), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_data_enable = 1'b0;
    bus.i_pixel = '0;
    model_reset();
    prev_rst_low = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'({bus.o_valid, bus.o_pixel, bus.o_col, bus.o_row, bus.o_sof,
          bus.o_eol, bus.o_locked, bus.o_err_line, bus.o_err_frame}), 64'd0);

    // search frame then acquisition and lock
    frame(V, -1, 0, rand_vb(), -1);
    check("no_valid_before_vblank", 64'(c_valid), 64'd0);
    clean_pair_relock("acquire");

    // short line while locked
    frame(V, int'($urandom_range(0, V - 1)), H - 1, rand_vb(), -1);
    check("short_errl", 64'(c_errl), 64'd1);
    check("short_errf", 64'(c_errf), 64'd0);
    check("short_unlock", 64'(bus.o_locked), 64'd0);
    clean_pair_relock("short");

    // dropped line while locked
    frame(V - 1, -1, 0, rand_vb(), -1);
    check("drop_errf", 64'(c_errf), 64'd1);
    check("drop_unlock", 64'(bus.o_locked), 64'd0);
    clean_pair_relock("drop");

    // overlong line
    frame(V, 2, 600, rand_vb(), -1);
    check("long_col_sat", 64'(max_col), 64'd511);
    check("long_errl", 64'(c_errl), 64'd1);
    clean_pair_relock("long");

    // one-cycle reset mid-frame
    frame(V, -1, 0, rand_vb(), int'($urandom_range(5, 3 * H)));
    check("post_reset_ignored", 64'(c_valid), 64'(snap_valid));
    check("reset_unlock", 64'(bus.o_locked), 64'd0);
    clean_pair_relock("reset");

    // single-cycle DE pulse line
    frame(V, 1, 1, rand_vb(), -1);
    check("pulse_errl", 64'(c_errl), 64'd1);
    check("pulse_eol", 64'(c_eol), 64'(V));
    clean_pair_relock("pulse");

    // blank one cycle short of the threshold merges two frames
    frame(V, -1, 0, GAP - 1, -1);
    check("merge_no_errf", 64'(c_errf), 64'd0);
    frame(V, -1, 0, rand_vb(), -1);
    check("merge_errf", 64'(c_errf), 64'd1);
    check("merge_unlock", 64'(bus.o_locked), 64'd0);
    // blank of exactly the threshold is a valid vblank
    frame(V, -1, 0, GAP, -1);
    frame(V, -1, 0, GAP, -1);
    check("exact_gap_lock", 64'(bus.o_locked), 64'd1);

    // random mix of line counts and line lengths
    for (int f = 0; f < 12; f++) begin
      int nl, ol, olen;
      nl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(V - 1, V + 1)) : V;
      ol   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      olen = int'($urandom_range(H - 2, H + 2));
      frame(nl, ol, olen, rand_vb(), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
